reg_file_pair: RTL and testbench

- Parametrised general-purpose register file for the CPU core.
- Provides two byte read ports, one pair read port and an independent write port.
- Supports register-pair operations: 16-bit-style add-immediate and pair move, with carry and zero flags from the pair add.
- Includes a sequential clear engine that zeroes the file one register per cycle without asserting reset; the core stalls on busy while it runs.

---
 rtl/reg_file_pair.sv | 137 +++++++++++++
 tb/tb_reg_file_pair.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_pair.sv
// General-purpose register file: two byte read ports, one pair read port, one write port,
// pair add-immediate / pair move with flags, and a one-register-per-cycle clear sweep.
module reg_file_pair #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CONST_W  = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             din,
  input  logic [$clog2(NUM_REGS)-1:0]   w_sel,
  input  logic                          write_en,
  input  logic [$clog2(NUM_REGS)-1:0]   a_sel,
  input  logic [$clog2(NUM_REGS)-1:0]   b_sel,
  input  logic                          pair_add,
  input  logic                          pair_move,
  input  logic [CONST_W-1:0]            constant,
  input  logic                          clr_start,
  output logic [DATA_W-1:0]             out_a,
  output logic [DATA_W-1:0]             out_b,
  output logic [2*DATA_W-1:0]           out_pair_b,
  output logic                          pair_carry,
  output logic                          pair_zero,
  output logic                          busy
);

  localparam int unsigned SEL_W  = $clog2(NUM_REGS);
  localparam int unsigned PAIR_W = 2 * DATA_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       rf_q [NUM_REGS];
  logic [DATA_W-1:0]       rf_d [NUM_REGS];
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;
  logic                    clear_en;

  // Pair addressing ignores the select LSB: low register even, high register odd.
  logic [SEL_W-1:0] a_lo, a_hi, b_lo, b_hi;
  assign a_lo = a_sel & ~SEL_W'(1);
  assign a_hi = a_sel | SEL_W'(1);
  assign b_lo = b_sel & ~SEL_W'(1);
  assign b_hi = b_sel | SEL_W'(1);

  logic [PAIR_W-1:0]        pair_a;
  logic signed [CONST_W-1:0] const_s;
  logic [PAIR_W-1:0]        const_ext;
  logic [PAIR_W:0]          sum;

  assign pair_a    = {rf_q[a_hi], rf_q[a_lo]};
  assign const_s   = constant;
  assign const_ext = PAIR_W'(const_s);
  assign sum       = {1'b0, pair_a} + {1'b0, const_ext};

  // Commands are accepted only while the sweep is idle; move takes precedence over add.
  logic do_move, do_add, do_pair, wr_hits_pair, do_write;
  assign do_move      = !clear_en && pair_move;
  assign do_add       = !clear_en && pair_add && !pair_move;
  assign do_pair      = do_move || do_add;
  assign wr_hits_pair = (w_sel | SEL_W'(1)) == a_hi;
  assign do_write     = !clear_en && write_en && !(do_pair && wr_hits_pair);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      rf_q    <= rf_d;
    end
  end

  // Clear FSM next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == SEL_W'(NUM_REGS - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clear_en = 1'b0;
    unique case (state_q)
      StIdle:  clear_en = 1'b0;
      StClear: clear_en = 1'b1;
      default: clear_en = 1'b0;
    endcase
  end

  // Register file and flag next-state
  always_comb begin
    rf_d    = rf_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (do_write) rf_d[w_sel] = din;
    if (do_move) begin
      rf_d[a_lo] = rf_q[b_lo];
      rf_d[a_hi] = rf_q[b_hi];
    end
    if (do_add) begin
      rf_d[a_lo] = sum[DATA_W-1:0];
      rf_d[a_hi] = sum[PAIR_W-1:DATA_W];
      carry_d    = sum[PAIR_W];
      zero_d     = (sum[PAIR_W-1:0] == '0);
    end
    if (clear_en) rf_d[idx_q] = '0;
  end

  assign out_a      = rf_q[a_sel];
  assign out_b      = rf_q[b_sel];
  assign out_pair_b = {rf_q[b_hi], rf_q[b_lo]};
  assign pair_carry = carry_q;
  assign pair_zero  = zero_q;
  assign busy       = clear_en;

endmodule

// File: tb/tb_reg_file_pair.sv
// Self-checking bench for reg_file_pair: directed scenarios plus random traffic against an
// array-based reference model.
module tb_reg_file_pair;

  localparam int NR = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  din;
  logic [3:0]  w_sel;
  logic        write_en;
  logic [3:0]  a_sel;
  logic [3:0]  b_sel;
  logic        pair_add;
  logic        pair_move;
  logic [8:0]  constant;
  logic        clr_start;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_pair_b;
  logic        pair_carry;
  logic        pair_zero;
  logic        busy;

  reg_file_pair #(
    .DATA_W  (8),
    .NUM_REGS(16),
    .CONST_W (9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .w_sel     (w_sel),
    .write_en  (write_en),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .pair_add  (pair_add),
    .pair_move (pair_move),
    .constant  (constant),
    .clr_start (clr_start),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_pair_b(out_pair_b),
    .pair_carry(pair_carry),
    .pair_zero (pair_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model
  int m_rf [NR];
  int m_carry;
  int m_zero;
  int m_busy_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int pair_of(input int s);
    return m_rf[s | 1] * 256 + m_rf[s & ~1];
  endfunction

  task automatic model_step();
    int nv;
    int sc;
    int s;
    bit op;
    nv = 0;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_rf[i] = 0;
      m_carry = 0;
      m_zero = 0;
      m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_rf[NR - m_busy_left] = 0;
      m_busy_left--;
    end else begin
      op = pair_move || pair_add;
      if (pair_move) begin
        nv = pair_of(int'(b_sel));
      end else if (pair_add) begin
        sc = int'(constant);
        if (sc >= 256) sc -= 512;
        s = pair_of(int'(a_sel)) + ((sc + 65536) % 65536);
        m_carry = (s >= 65536) ? 1 : 0;
        nv = s % 65536;
        m_zero = (nv == 0) ? 1 : 0;
      end
      if (write_en && !(op && (int'(w_sel) / 2 == int'(a_sel) / 2)))
        m_rf[int'(w_sel)] = int'(din);
      if (op) begin
        m_rf[int'(a_sel) & ~1] = nv % 256;
        m_rf[int'(a_sel) | 1]  = nv / 256;
      end
      if (clr_start) m_busy_left = NR;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("out_a", 32'(out_a), 32'(m_rf[int'(a_sel)]));
    chk("out_b", 32'(out_b), 32'(m_rf[int'(b_sel)]));
    chk("out_pair_b", 32'(out_pair_b), 32'(pair_of(int'(b_sel))));
    chk("pair_carry", 32'(pair_carry), 32'(m_carry));
    chk("pair_zero", 32'(pair_zero), 32'(m_zero));
    chk("busy", 32'(busy), 32'(m_busy_left > 0));
  endtask

  task automatic clr_inputs();
    write_en  = 1'b0;
    pair_add  = 1'b0;
    pair_move = 1'b0;
    clr_start = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic wr(input int s, input int d);
    clr_inputs();
    write_en = 1'b1;
    w_sel = 4'(s);
    din = 8'(d);
    step();
    clr_inputs();
  endtask

  task automatic set_pair(input int p, input int v);
    wr(p & ~1, v % 256);
    wr(p | 1, v / 256);
  endtask

  task automatic padd(input int a, input int c);
    clr_inputs();
    pair_add = 1'b1;
    a_sel = 4'(a);
    b_sel = 4'(a);
    constant = 9'(c);
    step();
    clr_inputs();
  endtask

  // Only valid while idle with no commands pending: the file cannot change across edges.
  task automatic check_all(input string tag, input int exp);
    for (int k = 0; k < NR; k++) begin
      a_sel = 4'(k);
      #1;
      chk(tag, 32'(out_a), 32'(exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input int v);
    for (int k = 0; k < NR; k++) wr(k, v);
  endtask

  int busy_cnt;

  initial begin
    din = '0; w_sel = '0; a_sel = '0; b_sel = '0; constant = '0;
    clr_inputs();
    for (int i = 0; i < NR; i++) m_rf[i] = 0;
    m_carry = 0; m_zero = 0; m_busy_left = 0;

    reset = 1'b1;
    step();
    clr_inputs();
    check_all("reset_rf", 0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Pair add with odd select
    set_pair(2, 16'h00FF);
    padd(3, 1);
    chk("add_odd_pair", 32'(out_pair_b), 32'h0100);
    chk("add_odd_carry", 32'(pair_carry), 32'd0);
    chk("add_odd_zero", 32'(pair_zero), 32'd0);

    // Negative immediate, first add wraps to zero
    set_pair(0, 16'h0001);
    padd(0, 9'h1FF);
    chk("neg1_pair", 32'(out_pair_b), 32'h0000);
    chk("neg1_carry", 32'(pair_carry), 32'd1);
    chk("neg1_zero", 32'(pair_zero), 32'd1);

    // Move wins over add; flags stay at 1/1
    set_pair(4, 16'hBEEF);
    pair_move = 1'b1; pair_add = 1'b1; constant = 9'h005;
    a_sel = 4'd14; b_sel = 4'd5;
    step();
    clr_inputs();
    chk("move_src", 32'(out_pair_b), 32'hBEEF);
    b_sel = 4'd15;
    #1;
    chk("move_dst", 32'(out_pair_b), 32'hBEEF);
    chk("move_carry_hold", 32'(pair_carry), 32'd1);
    chk("move_zero_hold", 32'(pair_zero), 32'd1);

    // Self-copy
    pair_move = 1'b1; a_sel = 4'd4; b_sel = 4'd5;
    step();
    clr_inputs();
    chk("move_self", 32'(out_pair_b), 32'hBEEF);

    // Second negative add
    padd(0, 9'h1FF);
    chk("neg2_pair", 32'(out_pair_b), 32'hFFFF);
    chk("neg2_carry", 32'(pair_carry), 32'd0);
    chk("neg2_zero", 32'(pair_zero), 32'd0);

    // Write inside target pair is discarded
    set_pair(2, 16'h1234);
    write_en = 1'b1; w_sel = 4'd2; din = 8'hAA;
    pair_add = 1'b1; a_sel = 4'd2; b_sel = 4'd2; constant = 9'd1;
    step();
    clr_inputs();
    chk("ovl_in_pair", 32'(out_pair_b), 32'h1235);

    // Write outside target pair commits alongside
    set_pair(2, 16'h1234);
    write_en = 1'b1; w_sel = 4'd6; din = 8'hAA;
    pair_add = 1'b1; a_sel = 4'd2; b_sel = 4'd2; constant = 9'd1;
    step();
    clr_inputs();
    chk("ovl_out_pair", 32'(out_pair_b), 32'h1235);
    a_sel = 4'd6;
    #1;
    chk("ovl_out_wr", 32'(out_a), 32'h00AA);

    // Clear sweep
    load_all(8'h5A);
    clr_start = 1'b1;
    step();
    clr_inputs();
    busy_cnt = busy ? 1 : 0;
    for (int j = 0; j < NR; j++) begin
      a_sel = 4'(j);
      b_sel = 4'((j + 1) % NR);
      if (j == 3) begin write_en = 1'b1; w_sel = 4'd0; din = 8'h77; end
      if (j == 5) begin pair_add = 1'b1; constant = 9'd1; end
      if (j == 7) clr_start = 1'b1;
      step();
      clr_inputs();
      if (busy) busy_cnt++;
      chk("sweep_cleared", 32'(out_a), 32'd0);
      if (j < NR - 1) chk("sweep_pending", 32'(out_b), 32'h5A);
    end
    for (int j = 0; j < 3; j++) begin
      step();
      if (busy) busy_cnt++;
    end
    chk("sweep_busy_len", 32'(busy_cnt), 32'd16);
    check_all("sweep_after", 0);

    // Reset in sweep cycle 5
    load_all(8'h5A);
    set_pair(0, 16'hFFFF);
    padd(0, 1);
    chk("pre_rst_carry", 32'(pair_carry), 32'd1);
    clr_start = 1'b1;
    step();
    clr_inputs();
    for (int j = 0; j < 5; j++) step();
    reset = 1'b1;
    step();
    clr_inputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_carry", 32'(pair_carry), 32'd0);
    chk("rst_zero", 32'(pair_zero), 32'd0);
    check_all("rst_rf", 0);
    wr(9, 8'h3C);
    a_sel = 4'd9;
    #1;
    chk("rst_then_wr", 32'(out_a), 32'h3C);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      clr_inputs();
      din       = 8'($urandom);
      w_sel     = 4'($urandom);
      a_sel     = 4'($urandom);
      b_sel     = 4'($urandom);
      constant  = 9'($urandom);
      write_en  = ($urandom_range(0, 1) == 1);
      pair_add  = ($urandom_range(0, 2) == 0);
      pair_move = ($urandom_range(0, 3) == 0);
      clr_start = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    clr_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
